cond_unit: RTL
==============

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 CLK  in  1  single clock; all state updates on rising edge.
REQ-002 RESET_N  in  1  reset, asynchronous, active-low.
REQ-003 ENE  in  1  execute-stage enable; 0 = stage stalled.
REQ-004 CondE  in  4  ARM condition field of the instruction in Execute.
REQ-005 FlagWriteE  in  2  [1] = update N,Z; [0] = update C,V.
REQ-006 ALUFlags  in  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-007 PCSrcE, RegWriteE, MemWriteE, BranchE  in  1 each  ungated control from the Decode/Execute register.
REQ-008 PCSrcGE, RegWriteGE, MemWriteGE  out  1 each  condition-gated controls toward the Execute/Memory register.
REQ-009 BranchTakenE  out  1  BranchE AND condition passed.
REQ-010 CondExE  out  1  condition-pass result.
REQ-011 FlagsQ  out  4  architectural flag register {N,Z,C,V}.

Function
REQ-012 CondExE SHALL be evaluated combinationally from CondE and FlagsQ (the pre-update flags, never ALUFlags).
REQ-013 Code map: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1.
REQ-014 Gated outputs SHALL equal the ungated input AND CondExE AND ENE; with ENE=0, all gated outputs and BranchTakenE are 0.
REQ-015 On a rising edge with ENE=1 and CondExE=1: FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0]; each pair updates independently.
REQ-016 A failed condition, ENE=0, or FlagWriteE=00 SHALL leave FlagsQ unchanged.
REQ-017 Flag update latency is one cycle: an instruction in cycle t sees flags written by the instruction in cycle t-1.
REQ-018 Back-to-back flag writers SHALL chain correctly; the second instruction evaluates its condition against the first instruction's written flags.

Reset
REQ-019 RESET_N low SHALL immediately clear FlagsQ to 0000, independent of CLK.
REQ-020 During reset, all gated outputs, BranchTakenE, and CondExE reflect FlagsQ=0000; a pending flag write in the same cycle SHALL be discarded.
REQ-021 After RESET_N deasserts, the first flag update SHALL occur on the first rising edge with RESET_N high.

Configuration
REQ-022 Macro COND_STATS_EN: when defined, add outputs ExecCount[15:0] and SquashCount[15:0].
REQ-023 ExecCount SHALL increment on each enabled cycle with CondExE=1; SquashCount SHALL increment on each enabled cycle with CondExE=0.
REQ-024 Both counters SHALL saturate at 16'hFFFF and clear asynchronously on reset.
REQ-025 Without COND_STATS_EN, neither the counters nor their ports exist, and all other behaviour is identical.

Verification
REQ-026 Reset, then CondE=0000 with FlagsQ=0000 and RegWriteE=1 -> CondExE=0, RegWriteGE=0.
REQ-027 Cycle 1: CondE=1110, FlagWriteE=11, ALUFlags=0100. Cycle 2: CondE=0000, MemWriteE=1 -> FlagsQ=0100 after cycle 1, MemWriteGE=1 in cycle 2.
REQ-028 FlagsQ=1001, CondE=1010, BranchE=1, PCSrcE=1 -> BranchTakenE=1, PCSrcGE=1; repeat with FlagsQ=1000 -> both 0.
REQ-029 FlagsQ=0000, FlagWriteE=01, ALUFlags=1111, CondE=1110 -> FlagsQ=0011 next cycle; repeat with CondE=0000 -> FlagsQ unchanged.
REQ-030 ENE=0 with FlagWriteE=11, CondE=1110, RegWriteE=1 -> RegWriteGE=0, FlagsQ held; drop RESET_N mid-cycle -> FlagsQ=0000 before the next edge.
REQ-031 With COND_STATS_EN: 3 passing and 2 failing enabled cycles -> ExecCount=3, SquashCount=2; preload to FFFF -> counters stay at FFFF.

Source files
------------

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Purpose  : ARM condition check on Execute: gates controls and owns the NZCV
//            flag register. Define COND_STATS_EN for exec/squash counters.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENE,
  input  logic [3:0]  CondE,
  input  logic [1:0]  FlagWriteE,
  input  logic [3:0]  ALUFlags,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  output logic        PCSrcGE,
  output logic        RegWriteGE,
  output logic        MemWriteGE,
  output logic        BranchTakenE,
  output logic        CondExE,
  output logic [3:0]  FlagsQ
`ifdef COND_STATS_EN
  ,
  output logic [15:0] ExecCount,
  output logic [15:0] SquashCount
`endif
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;
  logic cond_pass;
  logic exec_ok;

  // Condition is judged on the committed flags, never on this cycle's ALU result
  assign {n_flag, z_flag, c_flag, v_flag} = FlagsQ;

  always_comb begin
    cond_pass = 1'b1;
    case (CondE)
      4'b0000: cond_pass = z_flag;
      4'b0001: cond_pass = ~z_flag;
      4'b0010: cond_pass = c_flag;
      4'b0011: cond_pass = ~c_flag;
      4'b0100: cond_pass = n_flag;
      4'b0101: cond_pass = ~n_flag;
      4'b0110: cond_pass = v_flag;
      4'b0111: cond_pass = ~v_flag;
      4'b1000: cond_pass = c_flag & ~z_flag;
      4'b1001: cond_pass = ~c_flag | z_flag;
      4'b1010: cond_pass = (n_flag == v_flag);
      4'b1011: cond_pass = (n_flag != v_flag);
      4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_pass = z_flag | (n_flag != v_flag);
      default: cond_pass = 1'b1;
    endcase
  end

  assign exec_ok      = ENE & cond_pass;
  assign CondExE      = cond_pass;
  assign PCSrcGE      = PCSrcE    & exec_ok;
  assign RegWriteGE   = RegWriteE & exec_ok;
  assign MemWriteGE   = MemWriteE & exec_ok;
  assign BranchTakenE = BranchE   & exec_ok;

  // NZ and CV pairs load independently
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FlagsQ <= 4'b0000;
    end else if (exec_ok) begin
      if (FlagWriteE[1]) FlagsQ[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) FlagsQ[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ExecCount   <= 16'h0000;
      SquashCount <= 16'h0000;
    end else if (ENE) begin
      if (cond_pass) begin
        if (ExecCount != 16'hFFFF) ExecCount <= ExecCount + 16'd1;
      end else begin
        if (SquashCount != 16'hFFFF) SquashCount <= SquashCount + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
